// File: rtl/wb_queue.sv
// rtl/wb_queue.sv - write-back queue merging ALU and load results into one register-file write port
// Results drain in acceptance order; the read ports can bypass from pending entries.
module wb_queue #(
  parameter int DEPTH = 4
) (
  input  logic        Clk,
  input  logic        Clr,
  input  logic        Alu_valid,
  input  logic [4:0]  Alu_rd,
  input  logic [31:0] Alu_data,
  output logic        Alu_ready,
  input  logic        Mem_valid,
  input  logic [4:0]  Mem_rd,
  input  logic [31:0] Mem_data,
  output logic        Mem_ready,
  output logic [4:0]  Wr,
  output logic        We,
  output logic [31:0] D,
  input  logic [4:0]  Ra,
  input  logic [4:0]  Rb,
  output logic        Fa,
  output logic        Fb,
  output logic [31:0] Qa_fwd,
  output logic [31:0] Qb_fwd
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]    rd_q   [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d, alu_idx, idx;
  logic [CW-1:0] count_q, count_d, space;
  logic [4:0]    wr_q;
  logic          we_q;
  logic [31:0]   d_q;
  logic          pop, need_m, push_m, push_a;
  logic [1:0]    n_push;

  // The head leaves in the same edge, so its slot is already free for a push.
  assign space  = CW'(DEPTH) - count_q + CW'(count_q != '0);
  assign need_m = Mem_valid && (Mem_rd != 5'd0);

  assign Mem_ready = !Clr && ((space >= CW'(1)) || (Mem_rd == 5'd0));
  assign Alu_ready = !Clr && ((Alu_rd == 5'd0) || (space >= CW'(2)) ||
                              ((space >= CW'(1)) && !need_m));

  assign Wr = wr_q;
  assign We = we_q;
  assign D  = d_q;

  always_comb begin
    pop     = (count_q != '0);
    push_m  = Mem_valid && Mem_ready && (Mem_rd != 5'd0);
    push_a  = Alu_valid && Alu_ready && (Alu_rd != 5'd0);
    n_push  = {1'b0, push_m} + {1'b0, push_a};
    alu_idx = tail_q + AW'(push_m);
    head_d  = head_q + AW'(pop);
    tail_d  = tail_q + AW'(n_push);
    count_d = count_q - CW'(pop) + CW'(n_push);
  end

  always_ff @(posedge Clk) begin
    if (Clr) begin
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      we_q    <= 1'b0;
      wr_q    <= 5'd0;
      d_q     <= 32'd0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      we_q    <= pop;
      if (pop) begin
        wr_q <= rd_q[head_q];
        d_q  <= data_q[head_q];
      end
    end
  end

  // Mem entry is older than a same-cycle Alu entry, so it takes the tail slot first.
  always_ff @(posedge Clk) begin
    if (push_m) begin
      rd_q[tail_q]   <= Mem_rd;
      data_q[tail_q] <= Mem_data;
    end
    if (push_a) begin
      rd_q[alu_idx]   <= Alu_rd;
      data_q[alu_idx] <= Alu_data;
    end
  end

  // Oldest candidates first so the youngest match overwrites the result.
  always_comb begin
    Fa     = 1'b0;
    Fb     = 1'b0;
    Qa_fwd = 32'd0;
    Qb_fwd = 32'd0;
    idx    = head_q;
    if (we_q && (wr_q == Ra)) begin
      Fa     = 1'b1;
      Qa_fwd = d_q;
    end
    if (we_q && (wr_q == Rb)) begin
      Fb     = 1'b1;
      Qb_fwd = d_q;
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + AW'(i);
      if (CW'(i) < count_q) begin
        if (rd_q[idx] == Ra) begin
          Fa     = 1'b1;
          Qa_fwd = data_q[idx];
        end
        if (rd_q[idx] == Rb) begin
          Fb     = 1'b1;
          Qb_fwd = data_q[idx];
        end
      end
    end
    if (Clr || (Ra == 5'd0)) begin
      Fa     = 1'b0;
      Qa_fwd = 32'd0;
    end
    if (Clr || (Rb == 5'd0)) begin
      Fb     = 1'b0;
      Qb_fwd = 32'd0;
    end
  end

endmodule

// File: tb/tb_wb_queue.sv
// tb/tb_wb_queue.sv - scoreboard bench for wb_queue
// Stimulus pushes expected {Wr,D}; a negedge monitor pops and compares each write.
module tb_wb_queue;

  logic        Clk = 1'b0;
  logic        Clr = 1'b1;
  logic        Alu_valid = 1'b0;
  logic [4:0]  Alu_rd = 5'd0;
  logic [31:0] Alu_data = 32'd0;
  logic        Alu_ready;
  logic        Mem_valid = 1'b0;
  logic [4:0]  Mem_rd = 5'd0;
  logic [31:0] Mem_data = 32'd0;
  logic        Mem_ready;
  logic [4:0]  Wr;
  logic        We;
  logic [31:0] D;
  logic [4:0]  Ra = 5'd0;
  logic [4:0]  Rb = 5'd0;
  logic        Fa, Fb;
  logic [31:0] Qa_fwd, Qb_fwd;

  int checks = 0;
  int failures = 0;
  logic [36:0] exp_q[$];

  wb_queue #(.DEPTH(4)) dut (
    .Clk(Clk), .Clr(Clr),
    .Alu_valid(Alu_valid), .Alu_rd(Alu_rd), .Alu_data(Alu_data), .Alu_ready(Alu_ready),
    .Mem_valid(Mem_valid), .Mem_rd(Mem_rd), .Mem_data(Mem_data), .Mem_ready(Mem_ready),
    .Wr(Wr), .We(We), .D(D),
    .Ra(Ra), .Rb(Rb), .Fa(Fa), .Fb(Fb), .Qa_fwd(Qa_fwd), .Qb_fwd(Qb_fwd)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    Alu_valid = 1'b0;
    Mem_valid = 1'b0;
    Alu_rd    = 5'd0;
    Mem_rd    = 5'd0;
  endtask

  always @(negedge Clk) begin
    if (We) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write: got Wr=%0d D=0x%0h expected no write", Wr, D);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        if ({Wr, D} !== e) begin
          failures++;
          $display("FAIL write_order: got Wr=%0d D=0x%0h expected Wr=%0d D=0x%0h",
                   Wr, D, e[36:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int mcount, mi, ai, space;
    logic exp_a;

    // Reset; a result presented during Clr must be lost.
    Alu_valid = 1'b1; Alu_rd = 5'd7; Alu_data = 32'h7777; Ra = 5'd7;
    step();
    step();
    #1;
    check("rst_we", We, 0);
    check("rst_wr", Wr, 0);
    check("rst_d", D, 0);
    check("rst_alu_ready", Alu_ready, 0);
    check("rst_mem_ready", Mem_ready, 0);
    check("rst_fa", Fa, 0);
    idle_inputs();
    Clr = 1'b0;
    step();

    // Single write, latency 2, then output-stage bypass on Rb.
    Alu_valid = 1'b1; Alu_rd = 5'd5; Alu_data = 32'h1234;
    #1;
    check("single_alu_ready", Alu_ready, 1);
    exp_q.push_back({5'd5, 32'h1234});
    step();
    idle_inputs();
    Ra = 5'd5;
    #1;
    check("single_no_bypass_we", We, 0);
    check("single_fwd_queue_fa", Fa, 1);
    check("single_fwd_queue_qa", Qa_fwd, 32'h1234);
    step();
    Rb = 5'd5;
    #1;
    check("single_we", We, 1);
    check("single_wr", Wr, 5);
    check("single_d", D, 32'h1234);
    check("outstage_fb", Fb, 1);
    check("outstage_qb", Qb_fwd, 32'h1234);
    step();
    check("single_we_off", We, 0);
    check("outstage_fb_off", Fb, 0);
    check("outstage_qb_off", Qb_fwd, 0);
    check("hold_wr", Wr, 5);

    // Simultaneous write to same rd: Mem older, Alu younger.
    Mem_valid = 1'b1; Mem_rd = 5'd3; Mem_data = 32'hAAAA;
    Alu_valid = 1'b1; Alu_rd = 5'd3; Alu_data = 32'hBBBB;
    Ra = 5'd3;
    #1;
    check("sim_mem_ready", Mem_ready, 1);
    check("sim_alu_ready", Alu_ready, 1);
    exp_q.push_back({5'd3, 32'hAAAA});
    exp_q.push_back({5'd3, 32'hBBBB});
    step();
    idle_inputs();
    #1;
    check("sim_fa_q", Fa, 1);
    check("sim_qa_q", Qa_fwd, 32'hBBBB);
    step();
    check("sim_d1", D, 32'hAAAA);
    check("sim_qa_mixed", Qa_fwd, 32'hBBBB);
    step();
    check("sim_d2", D, 32'hBBBB);
    check("sim_qa_out", Qa_fwd, 32'hBBBB);
    step();
    check("sim_fa_off", Fa, 0);
    check("sim_qa_off", Qa_fwd, 0);

    // r0 writes are accepted and discarded.
    Alu_valid = 1'b1; Alu_rd = 5'd0; Alu_data = 32'hFFFF;
    Mem_valid = 1'b1; Mem_rd = 5'd0; Mem_data = 32'hEEEE;
    Ra = 5'd0;
    #1;
    check("r0_alu_ready", Alu_ready, 1);
    check("r0_mem_ready", Mem_ready, 1);
    check("r0_fa", Fa, 0);
    step();
    idle_inputs();
    step();
    check("r0_we", We, 0);
    step();
    check("r0_we2", We, 0);

    // Fill: both channels valid every cycle across pointer wraps.
    mcount = 0; mi = 0; ai = 0;
    for (int k = 0; k < 10; k++) begin
      Mem_valid = 1'b1; Mem_rd = 5'((mi % 31) + 1); Mem_data = 32'hA000_0000 + mi;
      Alu_valid = 1'b1; Alu_rd = 5'(((ai + 15) % 31) + 1); Alu_data = 32'hB000_0000 + ai;
      space = 4 - mcount + ((mcount > 0) ? 1 : 0);
      exp_a = (space >= 2);
      #1;
      check("fill_mem_ready", Mem_ready, 1);
      check("fill_alu_ready", Alu_ready, exp_a);
      exp_q.push_back({Mem_rd, Mem_data});
      mi++;
      if (exp_a) begin
        exp_q.push_back({Alu_rd, Alu_data});
        ai++;
      end
      step();
      mcount = mcount - ((mcount > 0) ? 1 : 0) + 1 + (exp_a ? 1 : 0);
      if (k >= 1) check("fill_we_cont", We, 1);
    end
    idle_inputs();
    for (int t = 0; t < 20 && exp_q.size() != 0; t++) step();
    step();
    check("fill_drained", exp_q.size(), 0);

    // Mid-operation reset with 3 entries pending.
    Mem_valid = 1'b1; Mem_rd = 5'd10; Mem_data = 32'h10;
    Alu_valid = 1'b1; Alu_rd = 5'd11; Alu_data = 32'h11;
    exp_q.push_back({5'd10, 32'h10});
    exp_q.push_back({5'd11, 32'h11});
    step();
    Mem_rd = 5'd12; Mem_data = 32'h12;
    Alu_rd = 5'd13; Alu_data = 32'h13;
    exp_q.push_back({5'd12, 32'h12});
    exp_q.push_back({5'd13, 32'h13});
    step();
    Clr = 1'b1;
    Ra = 5'd11; Rb = 5'd13;
    #1;
    check("clr_alu_ready", Alu_ready, 0);
    check("clr_mem_ready", Mem_ready, 0);
    check("clr_fa", Fa, 0);
    check("clr_fb", Fb, 0);
    check("clr_qb", Qb_fwd, 0);
    step();
    exp_q.delete();
    Clr = 1'b0;
    idle_inputs();
    #1;
    check("postclr_we", We, 0);
    check("postclr_fa", Fa, 0);
    check("postclr_fb", Fb, 0);
    check("postclr_d", D, 0);
    for (int t = 0; t < 3; t++) begin
      step();
      check("postclr_no_write", We, 0);
    end

    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
